mealy_seq_detector: RTL and testbench

- Serial-bit Mealy sequence detector. Samples one input bit `x` per rising clock edge and compares it against a parameterized pattern (default 1101, MSB received first).
- Output `z` is combinational from the current state and the current `x`. It is high in the same cycle that the final pattern bit is present on `x`.
- Used as a pattern-spotting leaf block on serial bitstreams.

---
 rtl/seq_det_pkg.sv | 58 +++++
 rtl/mealy_seq_detector.sv | 42 ++++
 tb/tb_mealy_seq_detector.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration-time helpers for the serial Mealy sequence detector.
// The next-state table is built here by a constant function, so no table exists at run time.
package seq_det_pkg;

    localparam int unsigned MAX_LEN         = 16;
    localparam int unsigned DEFAULT_LEN     = 4;
    localparam logic [3:0]  DEFAULT_PATTERN = 4'b1101;
    localparam int unsigned ENTRY_W         = 4;

    // Entry (2*state + x) holds the next state for that state/input pair.
    typedef logic [2*MAX_LEN*ENTRY_W-1:0] next_tbl_t;

    function automatic int unsigned state_width(input int unsigned len);
        return (len <= 2) ? 1 : $clog2(len);
    endfunction

    // For each (state, x) the received history is the first `state` pattern bits plus x.
    // The next state is the longest proper prefix of the pattern that is a suffix of that
    // history; this one rule covers advance, mismatch fallback and overlapping restart.
    function automatic next_tbl_t kmp_table(
        input logic [MAX_LEN-1:0] pattern,
        input int unsigned        len,
        input bit                 overlap
    );
        next_tbl_t        tbl;
        logic [MAX_LEN:0] hist;
        int unsigned      best;
        bit               ok;
        tbl = '0;
        for (int unsigned s = 0; s < len; s++) begin
            for (int unsigned b = 0; b < 2; b++) begin
                hist = '0;
                for (int unsigned j = 0; j < s; j++) begin
                    hist[j] = pattern[len-1-j];
                end
                hist[s] = b[0];
                best = 0;
                for (int unsigned k = 1; (k < len) && (k <= s + 1); k++) begin
                    ok = 1'b1;
                    for (int unsigned i = 0; i < k; i++) begin
                        if (hist[s+1-k+i] != pattern[len-1-i]) begin
                            ok = 1'b0;
                        end
                    end
                    if (ok) begin
                        best = k;
                    end
                end
                if (!overlap && (s == len - 1) && (b[0] == pattern[0])) begin
                    best = 0;
                end
                tbl[(2*s+b)*ENTRY_W +: ENTRY_W] = ENTRY_W'(best);
            end
        end
        return tbl;
    endfunction

endpackage

// File: rtl/mealy_seq_detector.sv
// Serial-bit Mealy detector: z is high in the same cycle the final pattern bit is on x.
// State is the number of pattern prefix bits matched so far.
module mealy_seq_detector
    import seq_det_pkg::*;
#(
    parameter int unsigned    LEN     = DEFAULT_LEN,
    parameter logic [LEN-1:0] PATTERN = DEFAULT_PATTERN,
    parameter bit             OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic x,
    output logic z
);

    localparam int unsigned   SW       = state_width(LEN);
    localparam logic [SW-1:0] S0       = '0;
    localparam logic [SW-1:0] S_LAST   = SW'(LEN - 1);
    localparam next_tbl_t     NEXT_TBL = kmp_table(MAX_LEN'(PATTERN), LEN, OVERLAP);

    logic [SW-1:0] state_q;
    logic [SW-1:0] state_d;

    always_comb begin
        state_d = S0;
        z       = 1'b0;
        // Unreachable encodings (non power-of-2 LEN) fall through to S0.
        if (32'(state_q) < LEN) begin
            state_d = SW'(NEXT_TBL[{state_q, x} * ENTRY_W +: ENTRY_W]);
            z       = reset && (state_q == S_LAST) && (x == PATTERN[0]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Self-checking bench for mealy_seq_detector (pattern 1101), overlapping and non-overlapping.
module tb_mealy_seq_detector;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic x = 1'b0;
    logic z_ov;
    logic z_no;

    int checks = 0;
    int failures = 0;

    logic [3:0] pat = 4'b1101;
    bit hist_ov[$];
    bit hist_no[$];

    typedef struct {
        bit x;
        bit z_ov;
        bit z_no;
    } vec_t;
    vec_t vecs[16];

    mealy_seq_detector #(.LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1)) u_ov (
        .clk(clk), .reset(reset), .x(x), .z(z_ov)
    );
    mealy_seq_detector #(.LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b0)) u_no (
        .clk(clk), .reset(reset), .x(x), .z(z_no)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    // Reference: a match is the last four received bits (including current x) equal to 1101.
    function automatic bit ends_with_pat(input bit h[$], input bit b);
        int n;
        n = h.size();
        if (n < 3) return 1'b0;
        return (h[n-3] == pat[3]) && (h[n-2] == pat[2]) && (h[n-1] == pat[1]) && (b == pat[0]);
    endfunction

    task automatic model_push(input bit b);
        bit m;
        m = ends_with_pat(hist_no, b);
        hist_ov.push_back(b);
        hist_no.push_back(b);
        if (m) hist_no.delete();
    endtask

    task automatic drive(input bit b);
        @(negedge clk);
        x = b;
        #2;
    endtask

    task automatic step(input string tag, input bit b);
        drive(b);
        check({tag, " z_ov"}, z_ov, ends_with_pat(hist_ov, b));
        check({tag, " z_no"}, z_no, ends_with_pat(hist_no, b));
        model_push(b);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            drive(i[0] ? 1'b0 : 1'b1);
            check($sformatf("rst z_ov c%0d", i), z_ov, 1'b0);
            check($sformatf("rst z_no c%0d", i), z_no, 1'b0);
            check($sformatf("rst state c%0d", i), u_ov.state_q == 2'd0, 1'b1);
        end
        hist_ov.delete();
        hist_no.delete();
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    // bits[n-1-i] is sent in cycle i; expectations use the same indexing.
    task automatic run_seq(input string tag, input logic [15:0] bits, input int n,
                           input logic [15:0] e_ov, input logic [15:0] e_no);
        do_reset(2);
        for (int i = 0; i < n; i++) begin
            drive(bits[n-1-i]);
            check($sformatf("%s ov c%0d", tag, i), z_ov, e_ov[n-1-i]);
            check($sformatf("%s no c%0d", tag, i), z_no, e_no[n-1-i]);
            model_push(bits[n-1-i]);
        end
    endtask

    initial begin
        logic [15:0] s_bits;
        logic [15:0] s_ov;
        logic [15:0] s_no;
        s_bits = 16'b1101_0110_1101_0110;
        s_ov   = 16'b0001_0000_1001_0000;
        s_no   = 16'b0001_0000_1000_0000;
        for (int i = 0; i < 16; i++) begin
            vecs[i].x    = s_bits[15-i];
            vecs[i].z_ov = s_ov[15-i];
            vecs[i].z_no = s_no[15-i];
        end

        #1;
        check("reset z_ov", z_ov, 1'b0);
        check("reset z_no", z_no, 1'b0);
        do_reset(2);

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].x);
            check($sformatf("tbl ov c%0d", i), z_ov, vecs[i].z_ov);
            check($sformatf("tbl no c%0d", i), z_no, vecs[i].z_no);
            model_push(vecs[i].x);
        end

        run_seq("overlap", 16'b1101101, 7, 16'b0001001, 16'b0001000);
        run_seq("ones", 16'b1111101, 7, 16'b0000001, 16'b0000001);
        run_seq("fallback", 16'b11001101, 8, 16'b00000001, 16'b00000001);

        // Mid-sequence reset discards the partial 110.
        do_reset(2);
        step("mid a", 1'b1);
        step("mid b", 1'b1);
        step("mid c", 1'b0);
        @(negedge clk);
        reset = 1'b0;
        x = 1'b1;
        #2;
        check("mid rst z_ov", z_ov, 1'b0);
        check("mid rst state", u_ov.state_q == 2'd0, 1'b1);
        hist_ov.delete();
        hist_no.delete();
        @(negedge clk);
        reset = 1'b1;
        #1;
        step("mid after1", 1'b1);
        step("mid d", 1'b1);
        step("mid e", 1'b0);
        step("mid f", 1'b1);
        check("mid f hit", z_ov, 1'b1);

        // Asynchronous reset kills z and state between edges.
        do_reset(2);
        step("async a", 1'b1);
        step("async b", 1'b1);
        step("async c", 1'b0);
        @(negedge clk);
        x = 1'b1;
        #1;
        check("async pre z", z_ov, 1'b1);
        reset = 1'b0;
        #1;
        check("async z", z_ov, 1'b0);
        check("async state", u_ov.state_q == 2'd0, 1'b1);
        hist_ov.delete();
        hist_no.delete();
        @(negedge clk);
        reset = 1'b1;
        #1;

        // In S3, z follows x between edges while state holds.
        step("comb a", 1'b1);
        step("comb b", 1'b1);
        step("comb c", 1'b0);
        @(negedge clk);
        x = 1'b0;
        #1;
        check("comb x0 z", z_ov, 1'b0);
        x = 1'b1;
        #1;
        check("comb x1 z", z_ov, 1'b1);
        check("comb x1 z_no", z_no, 1'b1);
        x = 1'b0;
        #1;
        check("comb x0b z", z_ov, 1'b0);
        check("comb hold", u_ov.state_q == 2'd3, 1'b1);
        x = 1'b1;
        #1;
        check("comb x1b z", z_ov, 1'b1);
        model_push(1'b1);
        step("comb post a", 1'b1);
        step("comb post b", 1'b0);
        step("comb post c", 1'b1);

        // Random stream against the reference model, biased towards ones.
        for (int i = 0; i < 500; i++) begin
            step($sformatf("rnd %0d", i), ($urandom_range(0, 99) < 60));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
